// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and width helpers for the round-robin register-bank arbiter.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_DATA_W   = 4;

    // Requester ID width; never narrower than one bit.
    function automatic int ID_W(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int ADDR_W(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester-side bus of the register-bank arbiter.
// REG_ARB_LOCK_EN adds the per-requester lock vector.
interface reg_bank_arbiter_if
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W
);
    localparam int IDW = ID_W(NUM_REQ);
    localparam int AW  = ADDR_W(NUM_REGS);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*AW-1:0]     addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
`ifdef REG_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock;
`endif
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         rdata;
    logic                      rvalid;
    logic [IDW-1:0]            rid;
    logic                      busy;

    modport master (
`ifdef REG_ARB_LOCK_EN
        output lock,
`endif
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid, rid, busy
    );

    modport slave (
`ifdef REG_ARB_LOCK_EN
        input  lock,
`endif
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid, rid, busy
    );

endinterface

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request above last_winner, wrapping.
module rr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDW    = ID_W(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_winner,
    output logic [IDW-1:0]     winner,
    output logic               valid
);

    logic [IDW-1:0]     cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            // Candidate at distance gi+1 above last_winner, modulo NUM_REQ.
            logic [IDW:0] sum;
            assign sum       = {1'b0, last_winner} + (IDW+1)'(gi + 1);
            assign cand[gi]  = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ))
                                                         : sum[IDW-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner = cand[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin sequencer owning a small register bank; one access per IDLE/ACCESS/RESP pass.
// Optional REG_ARB_LOCK_EN lets a locked winner chain straight from RESP back to ACCESS.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    reg_bank_arbiter_if.slave          bus,
    output logic [NUM_REGS*DATA_W-1:0] bank_q
);

    localparam int IDW = ID_W(NUM_REQ);
    localparam int AW  = ADDR_W(NUM_REGS);
    localparam logic [NUM_REQ-1:0] GNT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [AW-1:0]     addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [DATA_W-1:0] bank_reg  [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.addr[gi*AW +: AW];
            assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
        end
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank_q
            assign bank_q[gi*DATA_W +: DATA_W] = bank_reg[gi];
        end
    endgenerate

    state_t             state_reg;
    logic [IDW-1:0]     last_winner_reg;
    logic [IDW-1:0]     op_id_reg;
    logic               op_we_reg;
    logic [AW-1:0]      op_addr_reg;
    logic [DATA_W-1:0]  op_wdata_reg;
    logic               locked_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic               rvalid_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic [IDW-1:0]     rid_reg;

    logic [IDW-1:0]     arb_winner;
    logic               arb_valid;
    logic               lock_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req         (bus.req),
        .last_winner (last_winner_reg),
        .winner      (arb_winner),
        .valid       (arb_valid)
    );

`ifdef REG_ARB_LOCK_EN
    assign lock_hit = bus.lock[op_id_reg] & bus.req[op_id_reg];
`else
    assign lock_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            last_winner_reg <= IDW'(NUM_REQ - 1);
            op_id_reg       <= '0;
            op_we_reg       <= 1'b0;
            op_addr_reg     <= '0;
            op_wdata_reg    <= '0;
            locked_reg      <= 1'b0;
            gnt_reg         <= '0;
            rvalid_reg      <= 1'b0;
            rdata_reg       <= '0;
            rid_reg         <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    gnt_reg    <= '0;
                    rvalid_reg <= 1'b0;
                    if (arb_valid) begin
                        op_id_reg    <= arb_winner;
                        op_we_reg    <= bus.we[arb_winner];
                        op_addr_reg  <= addr_arr[arb_winner];
                        op_wdata_reg <= wdata_arr[arb_winner];
                        locked_reg   <= 1'b0;
                        gnt_reg      <= GNT_ONE << arb_winner;
                        state_reg    <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt_reg <= '0;
                    if (op_we_reg) begin
                        bank_reg[op_addr_reg] <= op_wdata_reg;
                    end else begin
                        rdata_reg  <= bank_reg[op_addr_reg];
                        rid_reg    <= op_id_reg;
                        rvalid_reg <= 1'b1;
                    end
                    // A locked re-grant keeps the rotation pointer where arbitration left it.
                    if (!locked_reg) begin
                        last_winner_reg <= op_id_reg;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    rvalid_reg <= 1'b0;
                    if (lock_hit) begin
                        op_we_reg    <= bus.we[op_id_reg];
                        op_addr_reg  <= addr_arr[op_id_reg];
                        op_wdata_reg <= wdata_arr[op_id_reg];
                        locked_reg   <= 1'b1;
                        gnt_reg      <= GNT_ONE << op_id_reg;
                        state_reg    <= ACCESS;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.rvalid = rvalid_reg;
    assign bus.rdata  = rdata_reg;
    assign bus.rid    = rid_reg;
    assign bus.busy   = (state_reg != IDLE);

endmodule
